// File: rtl/gate_test_sequencer_if.sv
// -----------------------------------------------------------------------------
// gate_test_sequencer_if
//   Groups the signals between the gate test sequencer and its surroundings:
//   the run request and reference selection, the observed gate output, the
//   stimulus vector and the run status/result fields.
//
//   master : bench/top side. Drives start, op_sel and dut_out; observes the rest.
//   slave  : sequencer side. Observes start, op_sel and dut_out; drives the rest.
//
//   Signals
//     start       run request
//     op_sel      reference function: 00 AND, 01 OR, 10 XOR, 11 NAND
//     dut_out     output of the gate under test
//     stim        vector driven to the gate inputs       [N_INPUTS]
//     busy        a run is in progress
//     done        last run finished (sticky)
//     pass        done with no mismatches
//     err_count   mismatching vectors in the last run    [N_INPUTS+1]
//     fail_valid  at least one mismatch recorded this run
//     first_fail  stim value of the first mismatch       [N_INPUTS]
// -----------------------------------------------------------------------------
interface gate_test_sequencer_if #(
    parameter int N_INPUTS = 2
) ();

    logic                start;
    logic [1:0]          op_sel;
    logic                dut_out;
    logic [N_INPUTS-1:0] stim;
    logic                busy;
    logic                done;
    logic                pass;
    logic [N_INPUTS:0]   err_count;
    logic                fail_valid;
    logic [N_INPUTS-1:0] first_fail;

    modport master (
        output start, op_sel, dut_out,
        input  stim, busy, done, pass, err_count, fail_valid, first_fail
    );

    modport slave (
        input  start, op_sel, dut_out,
        output stim, busy, done, pass, err_count, fail_valid, first_fail
    );

endinterface

// File: rtl/gate_test_sequencer.sv
// -----------------------------------------------------------------------------
// gate_test_sequencer
//   Exhaustive stimulus and checking controller for a single-output
//   combinational gate. On start it walks stim through 0 .. 2^N_INPUTS-1,
//   holding each vector for HOLD_CYCLES clocks, then samples the gate output
//   once and compares it against the reduction function chosen by op_sel
//   (latched at start). Mismatches are counted and the first failing vector
//   is recorded. Each vector costs HOLD_CYCLES+1 clocks.
//
//   Parameters
//     N_INPUTS     number of gate inputs, 1..8
//     HOLD_CYCLES  clocks each vector is held before sampling, >= 1
//
//   Ports
//     clk   rising-edge clock
//     rst   synchronous, active-high reset (returns to IDLE, clears outputs)
//     bus   gate_test_sequencer_if.slave (see interface header)
// -----------------------------------------------------------------------------
module gate_test_sequencer #(
    parameter int N_INPUTS    = 2,
    parameter int HOLD_CYCLES = 10
) (
    input  logic                    clk,
    input  logic                    rst,
    gate_test_sequencer_if.slave    bus
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_DRIVE  = 2'd1;
    localparam logic [1:0] S_SAMPLE = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    localparam int CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [N_INPUTS-1:0] STIM_MAX = '1;

    logic [1:0]          state_q;
    logic [1:0]          op_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [N_INPUTS-1:0] stim_q;
    logic                busy_q;
    logic                done_q;
    logic                pass_q;
    logic [N_INPUTS:0]   err_q;
    logic                fail_valid_q;
    logic [N_INPUTS-1:0] first_fail_q;

    logic ref_bit;
    logic mismatch;

    // Expected gate output for the current vector under the latched function.
    // NOTE: every variable assigned in always_comb gets a value on all paths
    // (default first) so no latch is inferred.
    always_comb begin
        ref_bit = 1'b0;
        case (op_q)
            2'b00:   ref_bit = &stim_q;
            2'b01:   ref_bit = |stim_q;
            2'b10:   ref_bit = ^stim_q;
            default: ref_bit = ~&stim_q;
        endcase
        mismatch = (ref_bit != bus.dut_out);
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            op_q         <= 2'b00;
            cnt_q        <= '0;
            stim_q       <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            err_q        <= '0;
            fail_valid_q <= 1'b0;
            first_fail_q <= '0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (bus.start) begin
                        op_q         <= bus.op_sel;
                        stim_q       <= '0;
                        cnt_q        <= '0;
                        err_q        <= '0;
                        fail_valid_q <= 1'b0;
                        first_fail_q <= '0;
                        busy_q       <= 1'b1;
                        done_q       <= 1'b0;
                        pass_q       <= 1'b0;
                        state_q      <= S_DRIVE;
                    end
                end

                // Counter runs 0 .. HOLD_CYCLES-1, giving HOLD_CYCLES clocks
                // of stable stim before the sample cycle.
                S_DRIVE: begin
                    if (cnt_q == CNT_LAST) begin
                        state_q <= S_SAMPLE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end

                S_SAMPLE: begin
                    if (mismatch) begin
                        err_q <= err_q + 1'b1;
                        if (!fail_valid_q) begin
                            fail_valid_q <= 1'b1;
                            first_fail_q <= stim_q;
                        end
                    end
                    if (stim_q == STIM_MAX) begin
                        // Last vector: stim stays at all-ones. pass must also
                        // account for a mismatch on this very vector.
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        pass_q  <= (err_q == '0) && !mismatch;
                        state_q <= S_DONE;
                    end else begin
                        stim_q  <= stim_q + 1'b1;
                        cnt_q   <= '0;
                        state_q <= S_DRIVE;
                    end
                end

                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.stim       = stim_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.pass       = pass_q;
    assign bus.err_count  = err_q;
    assign bus.fail_valid = fail_valid_q;
    assign bus.first_fail = first_fail_q;

endmodule

// File: tb/tb_gate_test_sequencer.sv
// -----------------------------------------------------------------------------
// tb_gate_test_sequencer
//   Instance A: N_INPUTS=2, HOLD_CYCLES=10, driven by a modelled gate that is
//   either a 2-input AND or stuck-at-0. Expected run results are queued when a
//   run is launched; a monitor pops and compares them when done rises.
//   Instance B: N_INPUTS=3, HOLD_CYCLES=1 with a 3-input AND gate.
// -----------------------------------------------------------------------------
module tb_gate_test_sequencer;

    typedef struct {
        logic [2:0] err_count;
        logic [1:0] first_fail;
        logic       fail_valid;
        logic       pass;
        logic [1:0] stim;
    } result_t;

    logic clk;
    logic rst;
    logic dut_mode;  // 0: AND gate, 1: stuck-at-0

    int n_checks = 0;
    int n_fail   = 0;

    result_t exp_q[$];

    gate_test_sequencer_if #(.N_INPUTS(2)) ifa ();
    gate_test_sequencer_if #(.N_INPUTS(3)) ifb ();

    gate_test_sequencer #(.N_INPUTS(2), .HOLD_CYCLES(10)) u_dut_a (
        .clk (clk),
        .rst (rst),
        .bus (ifa.slave)
    );

    gate_test_sequencer #(.N_INPUTS(3), .HOLD_CYCLES(1)) u_dut_b (
        .clk (clk),
        .rst (rst),
        .bus (ifb.slave)
    );

    assign ifa.dut_out = dut_mode ? 1'b0 : &ifa.stim;
    assign ifb.dut_out = &ifb.stim;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: compares the queued result on each rising done.
    initial begin
        logic    done_prev;
        result_t e;
        done_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst && ifa.done && !done_prev) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("err_count",  ifa.err_count,  e.err_count);
                    check("first_fail", ifa.first_fail, e.first_fail);
                    check("fail_valid", ifa.fail_valid, e.fail_valid);
                    check("pass",       ifa.pass,       e.pass);
                    check("final_stim", ifa.stim,       e.stim);
                    check("busy_at_done", ifa.busy,     0);
                end
            end
            done_prev = ifa.done;
        end
    end

    // Launches a run on instance A and tracks it until done. With hold_start
    // the start request stays high through the run and op_sel is flipped to
    // AND partway through; both must be ignored.
    task automatic run_a(input logic [1:0] op, input logic mode, input result_t exp,
                         input bit hold_start);
        int n;
        @(negedge clk);
        dut_mode   = mode;
        ifa.op_sel = op;
        ifa.start  = 1'b1;
        exp_q.push_back(exp);
        @(posedge clk);
        #1;
        check("busy_after_start",  ifa.busy,       1);
        check("done_after_start",  ifa.done,       0);
        check("pass_after_start",  ifa.pass,       0);
        check("err_after_start",   ifa.err_count,  0);
        check("fv_after_start",    ifa.fail_valid, 0);
        check("stim_after_start",  ifa.stim,       0);
        if (!hold_start) begin
            @(negedge clk);
            ifa.start = 1'b0;
        end
        n = 0;
        while (n < 200) begin
            @(posedge clk);
            #1;
            n++;
            if (hold_start && n == 15) ifa.op_sel = 2'b00;
            if (ifa.done) break;
            if (n % 11 == 0) check("stim_step", ifa.stim, n / 11);
        end
        check("done_latency", n, 44);
        @(negedge clk);
        ifa.start = 1'b0;
    endtask

    initial begin
        result_t r;
        int n;

        rst        = 1'b1;
        dut_mode   = 1'b0;
        ifa.start  = 1'b0;
        ifa.op_sel = 2'b00;
        ifb.start  = 1'b0;
        ifb.op_sel = 2'b00;
        repeat (2) @(posedge clk);
        #1;
        check("rst_stim",       ifa.stim,       0);
        check("rst_busy",       ifa.busy,       0);
        check("rst_done",       ifa.done,       0);
        check("rst_pass",       ifa.pass,       0);
        check("rst_err",        ifa.err_count,  0);
        check("rst_fail_valid", ifa.fail_valid, 0);
        check("rst_first_fail", ifa.first_fail, 0);
        @(negedge clk);
        rst = 1'b0;

        // 1: AND gate vs AND reference
        r = '{err_count: 3'd0, first_fail: 2'b00, fail_valid: 1'b0, pass: 1'b1, stim: 2'b11};
        run_a(2'b00, 1'b0, r, 1'b0);

        // 2: stuck-at-0 gate vs AND reference, only 11 mismatches
        r = '{err_count: 3'd1, first_fail: 2'b11, fail_valid: 1'b1, pass: 1'b0, stim: 2'b11};
        run_a(2'b00, 1'b1, r, 1'b0);

        // 3: AND gate vs XOR reference, mismatches at 01, 10, 11
        r = '{err_count: 3'd3, first_fail: 2'b01, fail_valid: 1'b1, pass: 1'b0, stim: 2'b11};
        run_a(2'b10, 1'b0, r, 1'b0);

        // 4: reset 20 cycles into a run, then a clean rerun
        @(negedge clk);
        dut_mode   = 1'b1;
        ifa.op_sel = 2'b00;
        ifa.start  = 1'b1;
        @(negedge clk);
        ifa.start = 1'b0;
        repeat (19) @(negedge clk);
        check("midrun_busy", ifa.busy, 1);
        check("midrun_stim", ifa.stim, 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rst2_stim",       ifa.stim,       0);
        check("rst2_busy",       ifa.busy,       0);
        check("rst2_done",       ifa.done,       0);
        check("rst2_pass",       ifa.pass,       0);
        check("rst2_err",        ifa.err_count,  0);
        check("rst2_fail_valid", ifa.fail_valid, 0);
        check("rst2_first_fail", ifa.first_fail, 0);
        repeat (5) @(posedge clk);
        #1;
        check("rst2_stays_idle", ifa.busy, 0);
        @(negedge clk);
        rst = 1'b0;
        r = '{err_count: 3'd0, first_fail: 2'b00, fail_valid: 1'b0, pass: 1'b1, stim: 2'b11};
        run_a(2'b00, 1'b0, r, 1'b0);

        // 5: start held high, op_sel flipped mid-run: XOR result, one run only
        r = '{err_count: 3'd3, first_fail: 2'b01, fail_valid: 1'b1, pass: 1'b0, stim: 2'b11};
        run_a(2'b10, 1'b0, r, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        check("no_rerun_busy", ifa.busy, 0);
        check("done_sticky",   ifa.done, 1);
        // restart from DONE clears counts and runs again
        r = '{err_count: 3'd0, first_fail: 2'b00, fail_valid: 1'b0, pass: 1'b1, stim: 2'b11};
        run_a(2'b00, 1'b0, r, 1'b0);

        // 6: instance B, 3 inputs, HOLD_CYCLES=1
        @(negedge clk);
        ifb.start = 1'b1;
        @(posedge clk);
        #1;
        check("b_busy_after_start", ifb.busy, 1);
        @(negedge clk);
        ifb.start = 1'b0;
        n = 0;
        while (n < 100) begin
            @(posedge clk);
            #1;
            n++;
            if (ifb.done) break;
        end
        check("b_done_latency", n, 16);
        check("b_err_count",    ifb.err_count,  0);
        check("b_pass",         ifb.pass,       1);
        check("b_fail_valid",   ifb.fail_valid, 0);
        check("b_final_stim",   ifb.stim,       3'b111);

        repeat (3) @(posedge clk);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
